// File: rtl/conv2d_stream_3x3.sv
// Streaming 3x3 signed correlation over raster-scan frames, "valid" region only.
// Two line buffers feed a 3x3 window; a 2-stage pipeline forms products, then sum/round/saturate.
module conv2d_stream_3x3 #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int ACC_W  = DATA_W + COEF_W + 4;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'((2 ** SHIFT) / 2);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));
    localparam logic signed [COEF_W-1:0] K_DEFAULT [9] = '{
        COEF_W'(1), COEF_W'(2), COEF_W'(1),
        COEF_W'(2), COEF_W'(4), COEF_W'(2),
        COEF_W'(1), COEF_W'(2), COEF_W'(1)
    };

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            done_d;
    logic            v0_q, last0_q, v1_q, last1_q;
    logic            out_valid_q, out_last_q, frame_done_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic signed [COEF_W-1:0] coef_q [9];

    logic signed [DATA_W-1:0] lb0_q [IMG_W];
    logic signed [DATA_W-1:0] lb1_q [IMG_W];
    logic signed [DATA_W-1:0] win_q [3][3];
    logic signed [PROD_W-1:0] prod_q [9];

    logic advance, accept, last_px, win_ok;
    logic signed [ACC_W-1:0] sum_d, shifted_d;
    logic signed [OUT_W-1:0] sat_d;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance && (state_q != FLUSH);
    assign accept   = in_valid && in_ready;
    assign last_px  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE:  if (accept) state_d = RUN;
            RUN:   if (accept && last_px) state_d = FLUSH;
            FLUSH: if (out_valid_q && out_ready && out_last_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: blocking accumulation is correct inside always_comb; state elsewhere uses <= only.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++) begin
            sum_d = sum_d + ACC_W'(prod_q[i]);
        end
        shifted_d = (sum_d + RND) >>> SHIFT;
        if (shifted_d > OUT_MAX)      sat_d = OUT_MAX[OUT_W-1:0];
        else if (shifted_d < OUT_MIN) sat_d = OUT_MIN[OUT_W-1:0];
        else                          sat_d = shifted_d[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            v0_q         <= 1'b0;
            last0_q      <= 1'b0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) coef_q[i] <= K_DEFAULT[i];
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= done_d;
            if (advance) begin
                v0_q        <= accept && win_ok;
                last0_q     <= accept && last_px;
                v1_q        <= v0_q;
                last1_q     <= last0_q;
                out_valid_q <= v1_q;
                out_last_q  <= last1_q;
                if (v1_q) out_data_q <= sat_d;
            end
            // Kernel is frozen once a frame starts; only IDLE writes land.
            if (coef_we && state_q == IDLE && coef_addr < 4'd9) coef_q[coef_addr] <= coef_wdata;
        end
    end

    // NOTE: line buffers, window and products are not reset; validity flags gate their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_data;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_q[col_q];
            win_q[1][2] <= lb0_q[col_q];
            win_q[2][2] <= in_data;
        end
        if (advance && v0_q) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod_q[r*3+c] <= win_q[r][c] * coef_q[r*3+c];
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2d_stream_3x3.sv
// Directed bench for conv2d_stream_3x3: flat, ramp, saturation, kernel-write, reset and backpressure frames.
module tb_conv2d_stream_3x3;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);

    localparam int P_FLAT = 0, P_RAMP = 1, P_NEG = 2, P_127 = 3, P_M128 = 4;
    localparam int E_100 = 0, E_75 = 1, E_CENTER = 2, E_TAP2 = 3, E_127 = 4, E_M128 = 5, E_NEG = 6;

    logic       clk, rst;
    logic       in_valid, in_ready, coef_we, out_valid, out_ready, out_last, busy, frame_done;
    logic [7:0] in_data, coef_wdata, out_data;
    logic [3:0] coef_addr;
    logic       s0_in_ready, s0_out_valid, s0_out_last, s0_busy, s0_frame_done;
    logic [7:0] s0_out_data;

    int checks = 0, failures = 0, done_cnt = 0;
    bit rand_rdy = 0;
    int got_q[$], s0_q[$];
    bit got_l[$];

    conv2d_stream_3x3 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .frame_done(frame_done)
    );

    conv2d_stream_3x3 #(.SHIFT(0)) dut_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data),
        .out_last(s0_out_last), .busy(s0_busy), .frame_done(s0_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pix(input int mode, input int r, input int c);
        case (mode)
            P_FLAT:  return 100;
            P_RAMP:  return r * IMG_W + c;
            P_NEG:   return -(r * IMG_W + c);
            P_127:   return 127;
            default: return -128;
        endcase
    endfunction

    // k-th result comes from the window whose newest pixel is (r,c).
    function automatic int exp_val(input int mode, input int k);
        int r, c, p;
        r = 2 + k / (IMG_W - 2);
        c = 2 + k % (IMG_W - 2);
        case (mode)
            E_100:    return 100;
            E_75:     return 75;
            E_CENTER: return (r - 1) * IMG_W + (c - 1);
            E_TAP2: begin
                p = (r - 2) * IMG_W + c;
                return (3 * p + 1) / 2;
            end
            E_127:    return 127;
            E_M128:   return -128;
            default:  return -((r - 1) * IMG_W + (c - 1));
        endcase
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        bit stalled;
        int held_d;
        bit held_l;
        stalled = 0;
        held_d  = 0;
        held_l  = 0;
        forever begin
            @(negedge clk);
            if (stalled && !rst) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", $signed(out_data), held_d);
                check("stall_last", int'(out_last), int'(held_l));
            end
            stalled = out_valid && !out_ready && !rst;
            held_d  = $signed(out_data);
            held_l  = out_last;
            if (out_valid && out_ready) begin
                got_q.push_back($signed(out_data));
                got_l.push_back(out_last);
                s0_q.push_back($signed(s0_out_data));
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic send_px(input int d);
        bit acc;
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = 8'(d);
        do begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!acc && n < 200);
        if (!acc) check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_we    = 1'b1;
        coef_addr  = 4'(addr);
        coef_wdata = 8'(data);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic run_frame(input string name, input int pmode, input int emode,
                             input bit gaps, input int we_at, input bit chk_s0);
        int d0, ncyc, n_last, last_pos;
        got_q.delete();
        got_l.delete();
        s0_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            if (i == we_at) begin
                coef_we    = 1'b1;
                coef_addr  = 4'd4;
                coef_wdata = 8'd0;
            end
            send_px(pix(pmode, i / IMG_W, i % IMG_W));
            coef_we = 1'b0;
            if (i == IMG_W * IMG_H - 1) begin
                @(negedge clk);
                check({name, "_flush_in_ready"}, int'(in_ready), 0);
                check({name, "_flush_busy"}, int'(busy), 1);
            end else if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        ncyc = 0;
        while (done_cnt == d0 && ncyc < 500) begin
            @(posedge clk);
            #1;
            ncyc++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({name, "_frame_done"}, done_cnt - d0, 1);
        check({name, "_busy_end"}, int'(busy), 0);
        check({name, "_count"}, got_q.size(), NRES);
        n_last   = 0;
        last_pos = -1;
        foreach (got_q[k]) begin
            if (k < NRES) begin
                check($sformatf("%s_d%0d", name, k), got_q[k], exp_val(emode, k));
                if (chk_s0) check($sformatf("%s_s0_d%0d", name, k), s0_q[k], exp_val(emode, k));
            end
            if (got_l[k]) begin
                n_last++;
                last_pos = k;
            end
        end
        check({name, "_last_cnt"}, n_last, 1);
        check({name, "_last_pos"}, last_pos, NRES - 1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        run_frame("t1_flat", P_FLAT, E_100, 0, -1, 0);
        run_frame("t5_mid_we", P_FLAT, E_100, 0, 10, 0);
        run_frame("t5_idle_we", P_FLAT, E_75, 0, 0, 0);

        for (int i = 0; i < 9; i++) write_coef(i, (i == 4) ? 16 : 0);
        write_coef(12, 55);
        run_frame("t2_center", P_RAMP, E_CENTER, 0, -1, 0);

        write_coef(4, 0);
        write_coef(2, 24);
        run_frame("t2_tap2", P_RAMP, E_TAP2, 0, -1, 0);

        for (int i = 0; i < 9; i++) write_coef(i, 127);
        run_frame("t3_hi", P_127, E_127, 0, -1, 1);
        run_frame("t3_lo", P_M128, E_M128, 0, -1, 1);

        for (int i = 0; i < 20; i++) send_px(pix(P_RAMP, i / IMG_W, i % IMG_W));
        rst = 1'b1;
        @(negedge clk);
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_out_data", int'(out_data), 0);
        check("t6_out_last", int'(out_last), 0);
        check("t6_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame("t6_fresh", P_NEG, E_NEG, 0, -1, 0);

        rand_rdy = 1'b1;
        run_frame("t4_backpressure", P_RAMP, E_CENTER, 1, -1, 0);
        rand_rdy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
